// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: FSM states, control-word
// field layout, Datapath function-select opcodes and the NOP word.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP_ISSUE,
    ST_STEP_WAIT,
    ST_DONE
  } seq_state_e;

  // Control-word field positions: DA[15:13] AA[12:10] BA[9:7] MB[6] FS[5:2] MD[1] RW[0]
  localparam int unsigned CW_DA_MSB = 15;
  localparam int unsigned CW_DA_LSB = 13;
  localparam int unsigned CW_AA_MSB = 12;
  localparam int unsigned CW_AA_LSB = 10;
  localparam int unsigned CW_BA_MSB = 9;
  localparam int unsigned CW_BA_LSB = 7;
  localparam int unsigned CW_MB_BIT = 6;
  localparam int unsigned CW_FS_MSB = 5;
  localparam int unsigned CW_FS_LSB = 2;
  localparam int unsigned CW_MD_BIT = 1;
  localparam int unsigned CW_RW_BIT = 0;

  // Datapath function-select opcodes
  localparam logic [3:0] FS_MOVA = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_MOVB = 4'b1100;

  // No operation: nothing selected, register file write disabled
  localparam logic [15:0] CW_NOP = 16'h0000;

  // Assemble a control word from its fields
  function automatic logic [15:0] cw_pack(
    input logic [2:0] da,
    input logic [2:0] aa,
    input logic [2:0] ba,
    input logic       mb,
    input logic [3:0] fs,
    input logic       md,
    input logic       rw
  );
    return {da, aa, ba, mb, fs, md, rw};
  endfunction

endpackage

// File: rtl/control_sequencer_cw_store.sv
// Program store for the control sequencer: DEPTH x CW_W register file,
// synchronous write, combinational read with write-first bypass so a word
// written on the same edge that reads it is seen immediately.
module cw_store #(
  parameter int unsigned CW_W  = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [CW_W-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [CW_W-1:0] rdata_o
);

  logic [CW_W-1:0] mem_q [DEPTH];

  // Storage write; contents intentionally survive reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port with bypass of a same-cycle write to the same address
  always_comb begin
    rdata_o = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-sequencer feeding the Datapath control_word. Issues a loaded program
// either back-to-back (run mode) or one word per start pulse (step mode);
// each word is driven for exactly one cycle, NOP otherwise, and the Datapath
// flags produced by each issued word are captured.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned CW_W  = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step_mode,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [CW_W-1:0] prog_data,
  input  logic [PC_W:0]   prog_len,
  input  logic [3:0]      flags_in,
  output logic [CW_W-1:0] control_word,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic [3:0]      flags_q
);

  localparam int unsigned LEN_W = PC_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
  localparam logic [CW_W-1:0]  NOP_W   = CW_W'(CW_NOP);

  seq_state_e      state_q;
  logic [PC_W-1:0] pc_q;
  logic [LEN_W-1:0] len_q;
  logic [CW_W-1:0] cw_q;
  logic            busy_q;
  logic            done_q;
  logic [3:0]      flags_cap_q;

  logic            store_we;
  logic [PC_W-1:0] rd_addr;
  logic [CW_W-1:0] rd_data;
  logic [PC_W-1:0] pc_nxt;
  logic [LEN_W-1:0] len_sat;
  logic            at_last;
  logic            idle_like;
  logic            issuing;

  assign pc_nxt    = pc_q + PC_W'(1);
  assign len_sat   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign at_last   = ({1'b0, pc_q} == (len_q - LEN_W'(1)));
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign issuing   = (state_q == ST_RUN) || (state_q == ST_STEP_ISSUE);
  // busy_q is registered, so writes are only admitted from IDLE/DONE
  assign store_we  = prog_we && !busy_q;

  // Read address: word 0 when launching, otherwise the next word
  always_comb begin
    rd_addr = pc_nxt;
    if (idle_like) begin
      rd_addr = '0;
    end
  end

  cw_store #(
    .CW_W  (CW_W),
    .DEPTH (DEPTH),
    .AW    (PC_W)
  ) u_store (
    .clk_i   (clk),
    .we_i    (store_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Sequencer FSM with registered control word, pc, status and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      cw_q        <= NOP_W;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flags_cap_q <= '0;
    end else begin
      if (issuing) begin
        flags_cap_q <= flags_in;
      end
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && (prog_len != '0)) begin
            pc_q    <= '0;
            len_q   <= len_sat;
            cw_q    <= rd_data;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= step_mode ? ST_STEP_ISSUE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (at_last) begin
            cw_q    <= NOP_W;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            pc_q <= pc_nxt;
            cw_q <= rd_data;
          end
        end
        ST_STEP_ISSUE: begin
          cw_q <= NOP_W;
          if (at_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_STEP_WAIT;
          end
        end
        ST_STEP_WAIT: begin
          if (start) begin
            pc_q    <= pc_nxt;
            cw_q    <= rd_data;
            state_q <= ST_STEP_ISSUE;
          end
        end
        default: begin
          cw_q    <= NOP_W;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign control_word = cw_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign flags_q      = flags_cap_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed programs in run and
// step mode, with a per-cycle expected-output model and literal pins.
module tb_control_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, start, step_mode, prog_we;
  logic [2:0]  prog_addr;
  logic [15:0] prog_data;
  logic [3:0]  prog_len;
  logic [3:0]  flags_in;
  logic [15:0] control_word;
  logic [2:0]  pc;
  logic        busy, done;
  logic [3:0]  flags_q;

  always #5 clk = ~clk;

  control_sequencer #(
    .CW_W  (16),
    .DEPTH (8),
    .PC_W  (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .step_mode    (step_mode),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .prog_len     (prog_len),
    .flags_in     (flags_in),
    .control_word (control_word),
    .pc           (pc),
    .busy         (busy),
    .done         (done),
    .flags_q      (flags_q)
  );

  // Model: program contents and the outputs expected in the current cycle
  logic [15:0] mem_m [DEPTH];
  logic [15:0] exp_cw    = '0;
  logic [2:0]  exp_pc    = '0;
  logic        exp_busy  = 1'b0;
  logic        exp_done  = 1'b0;
  logic        exp_issue = 1'b0;
  logic [3:0]  exp_flags = '0;
  bit          chk_en    = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [15:0] obs_cw[$];
  bit          obs_busy[$];
  bit          obs_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cw", control_word, exp_cw);
      check("pc", pc, exp_pc);
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("flags", flags_q, exp_flags);
    end
  end

  // One clock; an edge that closes an issue cycle captures the flags
  task automatic tick();
    logic       was_issue;
    logic [3:0] f;
    was_issue = exp_issue;
    f = flags_in;
    @(posedge clk);
    #1;
    if (was_issue) exp_flags = f;
  endtask

  task automatic tick_obs();
    tick();
    obs_cw.push_back(control_word);
    obs_busy.push_back(busy);
    obs_done.push_back(done);
  endtask

  task automatic set_exp(input logic [15:0] cw, input logic [2:0] p,
                         input logic b, input logic d, input logic iss);
    exp_cw = cw; exp_pc = p; exp_busy = b; exp_done = d; exp_issue = iss;
  endtask

  task automatic clear_obs();
    obs_cw.delete(); obs_busy.delete(); obs_done.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_exp(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    exp_flags = 4'b0000;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    bit acc;
    acc = !exp_busy;
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    if (acc) mem_m[a] = d;
  endtask

  // Run-mode execution; optional reset at a given index, write attempt while
  // busy, fixed flag pattern, and a write to word 0 coinciding with start
  task automatic run_prog(input int len, input int abort_at, input bit poke,
                          input bit flag_pat, input bit wf, input logic [15:0] wf_data);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    clear_obs();
    prog_len = 4'(len); step_mode = 1'b0; start = 1'b1;
    if (wf) begin prog_we = 1'b1; prog_addr = 3'd0; prog_data = wf_data; end
    if (wf && !exp_busy) mem_m[0] = wf_data;
    for (int i = 0; i < n; i++) begin
      tick_obs();
      start = 1'b0; prog_we = 1'b0;
      set_exp(mem_m[i], 3'(i), 1'b1, 1'b0, 1'b1);
      if (flag_pat && i == 3) check("flag_word2", flags_q, 4'b1010);
      if (i == abort_at) begin
        do_reset();
        return;
      end
      flags_in = flag_pat ? ((i == 2) ? 4'b1010 : 4'b0001) : 4'(i * 5 + 1);
      start = (i == 1);
      if (poke && i == 1) begin prog_we = 1'b1; prog_addr = 3'd1; prog_data = 16'hFFFF; end
    end
    tick_obs();
    start = 1'b0; prog_we = 1'b0;
    if (n > 0) set_exp(16'h0000, 3'(n - 1), 1'b0, 1'b1, 1'b0);
  endtask

  // Step-mode execution: one start per word, gap idle cycles between them
  task automatic step_prog(input int len, input int gap);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    clear_obs();
    prog_len = 4'(len);
    for (int i = 0; i < n; i++) begin
      start = 1'b1; step_mode = 1'b1;
      tick_obs();
      start = 1'b0; step_mode = 1'b0;
      set_exp(mem_m[i], 3'(i), 1'b1, 1'b0, 1'b1);
      flags_in = 4'(i + 8);
      tick_obs();
      if (i == n - 1) set_exp(16'h0000, 3'(i), 1'b0, 1'b1, 1'b0);
      else            set_exp(16'h0000, 3'(i), 1'b1, 1'b0, 1'b0);
      if (i < n - 1) repeat (gap) tick_obs();
    end
  endtask

  function automatic int count_busy();
    int c = 0;
    foreach (obs_busy[k]) if (obs_busy[k]) c++;
    return c;
  endfunction

  function automatic int count_nonnop();
    int c = 0;
    foreach (obs_cw[k]) if (obs_cw[k] != 16'h0000) c++;
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; step_mode = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; prog_len = '0; flags_in = '0;
    tick(); tick();
    set_exp(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    exp_flags = 4'b0000;
    chk_en = 1'b1;
    check("rst_cw", control_word, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_flags", flags_q, 4'b0000);
    reset = 1'b0;

    write_word(3'd0, 16'h0003);
    write_word(3'd1, 16'h2483);
    write_word(3'd2, 16'h4409);
    write_word(3'd3, 16'h4133);
    write_word(3'd4, 16'h5A5A);
    write_word(3'd5, 16'h0C3C);
    write_word(3'd6, 16'hE001);
    write_word(3'd7, 16'h7FFE);

    // Default program in run mode
    run_prog(4, -1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("run_w0", obs_cw[0], 16'h0003);
    check("run_w1", obs_cw[1], 16'h2483);
    check("run_w2", obs_cw[2], 16'h4409);
    check("run_w3", obs_cw[3], 16'h4133);
    check("run_nop", obs_cw[4], 16'h0000);
    check("run_done4", obs_done[3], 1'b0);
    check("run_done5", obs_done[4], 1'b1);
    check("run_busy_cycles", count_busy(), 4);
    repeat (3) tick();

    // Flag capture pattern, restarted from DONE
    run_prog(4, -1, 1'b0, 1'b1, 1'b0, 16'h0);
    check("flags_final", flags_q, 4'b0001);
    tick();

    // Zero length from IDLE is ignored
    do_reset();
    run_prog(0, -1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("zlen_busy", busy, 1'b0);
    check("zlen_cw", control_word, 16'h0000);
    check("zlen_done", done, 1'b0);
    tick();

    // Reset mid-run at pc=2, then replay
    run_prog(4, 2, 1'b0, 1'b0, 1'b0, 16'h0);
    check("abort_cw", control_word, 16'h0000);
    check("abort_flags", flags_q, 4'b0000);
    check("abort_busy", busy, 1'b0);
    run_prog(4, -1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("replay_w0", obs_cw[0], 16'h0003);

    // Write while busy is ignored
    run_prog(4, -1, 1'b1, 1'b0, 1'b0, 16'h0);
    run_prog(4, -1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("poke_w1", obs_cw[1], 16'h2483);
    tick();

    // Step mode, starts 10 cycles apart
    step_prog(4, 8);
    check("step_words", count_nonnop(), 4);
    check("step_done", done, 1'b1);
    check("step_pc", pc, 3'd3);
    tick();

    // Length above DEPTH saturates
    run_prog(12, -1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("sat_busy_cycles", count_busy(), 8);
    check("sat_pc", pc, 3'd7);
    check("sat_w7", obs_cw[7], 16'h7FFE);

    // Write to word 0 on the accepting edge is seen first
    run_prog(1, -1, 1'b0, 1'b0, 1'b1, 16'h0ABC);
    check("wf_w0", obs_cw[0], 16'h0ABC);
    write_word(3'd0, 16'h0003);

    // Single-word step program
    step_prog(1, 0);
    check("step1_w0", obs_cw[0], 16'h0003);
    check("step1_done", done, 1'b1);
    tick(); tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised micro-sequencer that replaces the hand-wired mode counter in front of the Datapath. It holds a loadable program of up to DEPTH control words and issues them to the Datapath, either back-to-back (run mode) or one per start pulse (step mode). Each issued word is active for exactly one cycle. The block also latches the Datapath status flags produced by each issued word. It sits between the debounced push-button and switch logic and the Datapath `control_word` input.

## Interface
Parameters:
- CW_W, 16, control word width; field layout DA[15:13] AA[12:10] BA[9:7] MB[6] FS[5:2] MD[1] RW[0]
- DEPTH, 8, program store entries (power of two, ≥2)
- PC_W, $clog2(DEPTH), program counter / address width

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high; sampled on posedge clk
- start  in  1  one-cycle pulse, already debounced
- step_mode  in  1  1 = step mode, 0 = run mode; sampled only when a start is accepted
- prog_we  in  1  program write strobe
- prog_addr  in  PC_W  program write address
- prog_data  in  CW_W  program write data
- prog_len  in  PC_W+1  number of words to execute, 0..DEPTH
- flags_in  in  4  {V,C,N,Z} from the Datapath
- control_word  out  CW_W  registered word to the Datapath; NOP (all zeros, RW=0) when not issuing
- pc  out  PC_W  index of the word currently or last issued
- busy  out  1  high in RUN, STEP_ISSUE and STEP_WAIT
- done  out  1  high in DONE
- flags_q  out  4  {V,C,N,Z} captured at the end of the most recent issue cycle

## Operation
- States: IDLE, RUN, STEP_ISSUE, STEP_WAIT, DONE.
- Reset values: state=IDLE, control_word=0, pc=0, busy=0, done=0, flags_q=0. Program store contents are not reset.
- IDLE or DONE, start=1 and prog_len≠0:
  - pc←0 and control_word←mem[0].
  - Go to RUN if step_mode=0, otherwise STEP_ISSUE.
- IDLE or DONE, start=1 and prog_len=0: start ignored; state unchanged.
- RUN:
  - If pc==prog_len-1: control_word←NOP, go to DONE.
  - Otherwise pc←pc+1 and control_word←mem[pc+1].
  - start is ignored.
- STEP_ISSUE: lasts exactly one cycle.
  - Last word (pc==prog_len-1): go to DONE.
  - Otherwise go to STEP_WAIT.
  - control_word←NOP in both cases.
- STEP_WAIT: output NOP until start=1; then pc←pc+1, control_word←mem[pc+1], go to STEP_ISSUE.
- DONE: done=1, NOP output, pc holds the last index. A start restarts the program from word 0, as from IDLE.
- Flag capture: on every clock edge that ends a cycle with a non-NOP issue (RUN or STEP_ISSUE), flags_q←flags_in. flags_q holds at all other times.
- Program writes:
  - Accepted only when busy=0.
  - mem[prog_addr]←prog_data on the clock edge.
  - prog_we while busy=1 is ignored.
- prog_len:
  - Sampled together with step_mode when a start is accepted.
  - Values above DEPTH saturate to DEPTH.
  - Changes during execution have no effect.
- Reset mid-operation: returns to IDLE on the next edge, with NOP output and flags_q cleared. The program store is kept.
- Simultaneous start and prog_we in IDLE or DONE: the write takes effect first. The start is accepted, and word 0 is read after the write (write-first).

## Timing
- Start accepted at edge k → control_word=mem[0] valid from edge k through edge k+1.
- Run mode: N words occupy N consecutive cycles; done rises at edge k+N; busy is high for N cycles.
- Step mode: each accepted start produces exactly one issue cycle, followed by NOP. The Datapath therefore writes once per button press.
- control_word, pc, busy and done are all registered; no combinational path runs from inputs to outputs.
- flags_q updates one edge after the issue cycle it reflects.

## Structure
- Package `control_sequencer_pkg` holds:
  - state enum
  - CW field position constants (DA, AA, BA, MB, FS, MD, RW)
  - FS opcode constants: MOVA=4'b0000, ADD=4'b0010, MOVB=4'b1100
  - NOP constant
- Sub-module `cw_store`: DEPTH×CW_W register file with synchronous write and combinational read, write-first on address collision.
- The FSM and pc logic live in the top-level module.

## Test plan
- Default-program run: store {0x0003, 0x2483, 0x4409, 0x4133}, prog_len=4, step_mode=0, start → control_word is exactly those four values on four consecutive cycles, then 0; done=1 at the 5th edge; busy high for 4 cycles.
- Step mode, same program: four starts spaced 10 cycles apart → each word appears for exactly one cycle after its start, with NOP between starts; done is set after the 4th word.
- prog_len=0, start → state stays IDLE, control_word=0, busy=0.
- Reset asserted during RUN at pc=2 → next edge: IDLE, control_word=0, flags_q=0. A following start replays from mem[0] with the program intact.
- prog_we to addr 1 with 0xFFFF while busy → ignored; rerun shows the original mem[1].
- Flag capture: flags_in=4'b1010 during the issue of word 2 and 4'b0001 afterwards → flags_q=4'b1010 one edge after word 2. The final value reflects the last issued word.
